// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan driver: FSM states, glyph table
// and the leading-zero blanking helper.
package seg_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  // All segments and the decimal point off (outputs are active-low)
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a} glyphs for hex 0..F, decimal point off
  localparam logic [7:0] SEG_HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Marks every digit above the highest non-zero nibble; digit 0 always shows
  function automatic logic [7:0] lzBlankMask(input logic [31:0] value);
    logic [7:0] mask;
    logic       seen;
    mask = 8'h00;
    seen = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      seen    = seen | (value[4*i +: 4] != 4'h0);
      mask[i] = ~seen;
    end
    return mask;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Converts one hex nibble plus decimal point into an active-low segment
// pattern; a blanked digit still drives its decimal point.
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  // Glyph lookup, with the seven segments forced off for suppressed digits
  always_comb begin
    o_seg[7]   = ~i_dp;
    o_seg[6:0] = i_blank ? 7'h7F : SEG_HEX[i_nibble][6:0];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 8-digit display driver. One digit is advanced on
// each rising edge of a chosen clkdiv bit, with a short all-off gap before
// every digit. New values are held pending and only swapped in when the scan
// wraps back to digit 0, so a frame never mixes old and new digits.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_BIT     = 17,
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 16,
  parameter int LZ_SUPPRESS  = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_clkdiv,
  input  logic [31:0] i_data,
  input  logic [7:0]  i_dpIn,
  input  logic        i_load,
  output logic        o_pending,
  output logic        o_frameDone,
  output logic [7:0]  o_an,
  output logic [7:0]  o_seg
);

  localparam logic [2:0] LAST_IDX   = 3'(NUM_DIGITS - 1);
  localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYCLES - 1);

  logic        r_bitQ;
  scan_state_t r_state;
  logic [7:0]  r_blankCnt;
  logic [2:0]  r_idx;
  logic [31:0] r_shadowData;
  logic [7:0]  r_shadowDp;
  logic [7:0]  r_lzMask;
  logic [31:0] r_pendData;
  logic [7:0]  r_pendDp;
  logic        r_pending;

  logic        w_step;
  logic        w_commit;
  logic [3:0]  w_nibble;
  logic [7:0]  w_digitSeg;
  logic        w_unusedClkdiv;

  // Only one divider bit drives the scan; the rest of the bus is ignored
  assign w_unusedClkdiv = ^i_clkdiv;

  assign w_step    = i_clkdiv[SCAN_BIT] & ~r_bitQ;
  assign w_commit  = (r_state == ST_SHOW) && w_step && (r_idx == LAST_IDX);
  assign w_nibble  = r_shadowData[{r_idx, 2'b00} +: 4];
  assign o_pending = r_pending;

  hex_to_seg7 u_hexToSeg7 (
    .i_nibble (w_nibble),
    .i_dp     (r_shadowDp[r_idx]),
    .i_blank  (r_lzMask[r_idx]),
    .o_seg    (w_digitSeg)
  );

  // Delayed copy of the scan bit for rising-edge detection
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bitQ <= 1'b0;
    end else begin
      r_bitQ <= i_clkdiv[SCAN_BIT];
    end
  end

  // Scan FSM: blank gap, then light digit idx until the next step; outputs lag state by one clock
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_BLANK;
      r_blankCnt  <= 8'd0;
      r_idx       <= 3'd0;
      o_an        <= 8'hFF;
      o_seg       <= SEG_OFF;
      o_frameDone <= 1'b0;
    end else begin
      o_frameDone <= w_commit;
      case (r_state)
        ST_BLANK: begin
          o_an  <= 8'hFF;
          o_seg <= SEG_OFF;
          if (r_blankCnt == BLANK_LAST) begin
            r_state <= ST_SHOW;
          end else begin
            r_blankCnt <= r_blankCnt + 8'd1;
          end
        end
        ST_SHOW: begin
          o_an  <= ~(8'h01 << r_idx);
          o_seg <= w_digitSeg;
          if (w_step) begin
            r_state    <= ST_BLANK;
            r_blankCnt <= 8'd0;
            r_idx      <= (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
          end
        end
      endcase
    end
  end

  // Pending capture and frame-boundary commit into the displayed shadow copy
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending    <= 1'b0;
      r_pendData   <= 32'd0;
      r_pendDp     <= 8'd0;
      r_shadowData <= 32'd0;
      r_shadowDp   <= 8'd0;
      r_lzMask     <= 8'd0;
    end else if (w_commit) begin
      r_pending <= 1'b0;
      if (i_load) begin
        r_shadowData <= i_data;
        r_shadowDp   <= i_dpIn;
        r_lzMask     <= (LZ_SUPPRESS != 0) ? lzBlankMask(i_data) : 8'h00;
      end else if (r_pending) begin
        r_shadowData <= r_pendData;
        r_shadowDp   <= r_pendDp;
        r_lzMask     <= (LZ_SUPPRESS != 0) ? lzBlankMask(r_pendData) : 8'h00;
      end
    end else if (i_load) begin
      r_pendData <= i_data;
      r_pendDp   <= i_dpIn;
      r_pending  <= 1'b1;
    end
  end

endmodule
